// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated multi-channel frequency meter.
package freq_meter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_BOTH = 1'b1;

  localparam int unsigned DEF_N_CH        = 1;
  localparam int unsigned DEF_CNT_W       = 40;
  localparam int unsigned DEF_GATE_W      = 32;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/freq_edge_detect.sv
// One input channel: multi-stage synchroniser, history flop and edge pulse.
// The pulse is combinational so pin-to-count latency stays SYNC_STAGES+1 cycles.
module freq_edge_detect
  import freq_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  input  logic edge_mode,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   level;

  assign level = sync[SYNC_STAGES-1];

  // synchroniser chain and previous-level history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= {SYNC_STAGES{1'b0}};
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      hist <= level;
    end
  end

  // edge qualification by mode
  always_comb begin
    if (edge_mode == EDGE_BOTH) begin
      edge_pulse = level ^ hist;
    end else begin
      edge_pulse = level & ~hist;
    end
  end

endmodule

// File: rtl/freq_meter_gated.sv
// Gated frequency meter: shared gate timer and FSM, per-channel saturating
// edge counters, results published together at the end of every window.
module freq_meter_gated
  import freq_meter_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned GATE_W      = DEF_GATE_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [GATE_W-1:0]      gate_len,
  input  logic                   edge_mode,
  input  logic [N_CH-1:0]        sig_in,
  output logic [N_CH*CNT_W-1:0]  count_out,
  output logic                   count_valid,
  output logic [N_CH-1:0]        overflow,
  output logic                   busy
);

  localparam logic [GATE_W-1:0] GATE_ZERO = {GATE_W{1'b0}};
  localparam logic [GATE_W-1:0] GATE_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t            state;
  state_t            state_next;
  logic [GATE_W-1:0] timer;
  logic              edge_mode_q;
  logic              load;
  logic              publish;
  logic              run;
  logic [N_CH-1:0]   edge_pulse;
  logic [N_CH-1:0]   ovf_q;
  logic [N_CH-1:0]   ovf_next;
  logic [CNT_W-1:0]  cnt      [N_CH];
  logic [CNT_W-1:0]  cnt_next [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    freq_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
      .clk        (clk),
      .reset      (reset),
      .sig_in     (sig_in[g]),
      .edge_mode  (edge_mode_q),
      .edge_pulse (edge_pulse[g])
    );
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state; a window end with enable high reloads in the same cycle
  always_comb begin
    state_next = state;
    load       = 1'b0;
    publish    = 1'b0;
    run        = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (gate_len != GATE_ZERO)) begin
          state_next = GATE;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      GATE: begin
        if (timer == GATE_ZERO) begin
          publish = 1'b1;
          if (enable && (gate_len != GATE_ZERO)) begin
            state_next = GATE;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (enable) begin
          state_next = GATE;
          run        = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // gate timer and mode latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer       <= GATE_ZERO;
      edge_mode_q <= EDGE_RISE;
    end else if (load) begin
      timer       <= gate_len - GATE_ONE;
      edge_mode_q <= edge_mode;
    end else if (run) begin
      timer       <= timer - GATE_ONE;
      edge_mode_q <= edge_mode_q;
    end else begin
      timer       <= timer;
      edge_mode_q <= edge_mode_q;
    end
  end

  // saturating increment including this cycle's edge
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_next[i] = cnt[i];
      ovf_next[i] = ovf_q[i];
      if (edge_pulse[i]) begin
        if (cnt[i] == CNT_MAX) begin
          ovf_next[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CNT_ONE;
        end
      end else begin
        cnt_next[i] = cnt[i];
      end
    end
  end

  // counters accumulate mid-window, otherwise restart from zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= CNT_ZERO;
      end
      ovf_q <= {N_CH{1'b0}};
    end else if (run) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_next[i];
      end
      ovf_q <= ovf_next;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= CNT_ZERO;
      end
      ovf_q <= {N_CH{1'b0}};
    end
  end

  // published results and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_out   <= {(N_CH*CNT_W){1'b0}};
      overflow    <= {N_CH{1'b0}};
      count_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      count_valid <= publish;
      busy        <= (state_next == GATE);
      if (publish) begin
        for (int i = 0; i < N_CH; i++) begin
          count_out[i*CNT_W +: CNT_W] <= cnt_next[i];
        end
        overflow <= ovf_next;
      end else begin
        count_out <= count_out;
        overflow  <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_gated.sv
// Bench for freq_meter_gated: edge-counting reference model compared every
// cycle, directed windows with hand-computed results, then random traffic.
module tb_freq_meter_gated;

  localparam int NC   = 3;
  localparam int CW   = 6;
  localparam int GW   = 16;
  localparam int S    = 2;
  localparam int MAXC = 63;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [GW-1:0]    gate_len = '0;
  logic             edge_mode = 1'b0;
  logic [NC-1:0]    sig_in = '0;
  logic [NC*CW-1:0] count_out;
  logic             count_valid;
  logic [NC-1:0]    overflow;
  logic             busy;

  freq_meter_gated #(
    .N_CH (NC), .CNT_W (CW), .GATE_W (GW), .SYNC_STAGES (S)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable), .gate_len (gate_len),
    .edge_mode (edge_mode), .sig_in (sig_in), .count_out (count_out),
    .count_valid (count_valid), .overflow (overflow), .busy (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ch_cnt(input int ch);
    return int'(count_out[ch*CW +: CW]);
  endfunction

  // ---------------- stimulus generator ----------------
  int period[NC] = '{0, 0, 0};
  int phase[NC]  = '{0, 3, 5};
  bit rnd[NC]    = '{0, 0, 0};
  int hold[NC]   = '{3, 3, 3};
  int cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NC; c++) begin
        if (rnd[c]) begin
          if (hold[c] <= 1) begin
            sig_in[c] = ~sig_in[c];
            hold[c] = $urandom_range(2, 7);
          end else begin
            hold[c]--;
          end
        end else if (period[c] == 0) begin
          sig_in[c] = 1'b0;
        end else begin
          sig_in[c] = (((cyc + phase[c]) % period[c]) < (period[c] / 2));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  int  h[NC][S+1];
  int  tcnt[NC];
  bit  win_on = 0;
  int  rem = 0;
  bit  mq = 0;
  bit  exp_valid = 0;
  bit  exp_busy = 0;
  int  exp_cnt[NC] = '{0, 0, 0};
  bit  exp_ovf[NC] = '{0, 0, 0};

  task automatic model_step();
    bit can_start;
    int lvl, old;
    if (reset) begin
      win_on = 0; rem = 0; exp_valid = 0; exp_busy = 0;
      for (int c = 0; c < NC; c++) begin
        exp_cnt[c] = 0; exp_ovf[c] = 0; tcnt[c] = 0;
        for (int j = 0; j <= S; j++) h[c][j] = 0;
      end
    end else begin
      can_start = !win_on;
      exp_valid = 0;
      if (win_on) begin
        for (int c = 0; c < NC; c++) begin
          lvl = h[c][S-1];
          old = h[c][S];
          if (mq ? (lvl != old) : (lvl == 1 && old == 0)) tcnt[c]++;
        end
        if (rem == 1) begin
          for (int c = 0; c < NC; c++) begin
            exp_cnt[c] = (tcnt[c] > MAXC) ? MAXC : tcnt[c];
            exp_ovf[c] = (tcnt[c] > MAXC);
          end
          exp_valid = 1;
          win_on = 0;
          can_start = 1;
        end else if (!enable) begin
          win_on = 0;
        end else begin
          rem--;
        end
      end
      if (can_start && enable && gate_len != 0) begin
        win_on = 1; rem = int'(gate_len); mq = edge_mode;
        for (int c = 0; c < NC; c++) tcnt[c] = 0;
      end
      exp_busy = win_on;
      for (int c = 0; c < NC; c++) begin
        for (int j = S; j > 0; j--) h[c][j] = h[c][j-1];
        h[c][0] = int'(sig_in[c]);
      end
    end
  endtask

  // per-cycle compare, a little after the active edge
  always @(posedge clk) begin
    logic [NC*CW-1:0] ecnt;
    logic [NC-1:0]    eovf;
    model_step();
    #1;
    for (int c = 0; c < NC; c++) begin
      ecnt[c*CW +: CW] = CW'(exp_cnt[c]);
      eovf[c] = exp_ovf[c];
    end
    check("count_valid", count_valid, exp_valid);
    check("busy", busy, exp_busy);
    check("overflow", overflow, eovf);
    check("count_out", count_out, ecnt);
  end

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (count_valid !== 1'b1 && n < maxc);
    if (count_valid !== 1'b1) check("valid_timeout", count_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, seen, prev;
    period = '{10, 20, 0};
    repeat (3) @(negedge clk);
    check("rst_count_out", count_out, 0);
    check("rst_valid", count_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;

    // rising edges, 100-cycle windows back to back
    gate_len = 16'd100;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    wait_valid(150, n);
    check("rise_ch0", ch_cnt(0), 10);
    check("rise_ch1", ch_cnt(1), 5);
    check("rise_ch2", ch_cnt(2), 0);
    check("rise_ovf", overflow, 0);
    wait_valid(150, n);
    check("window_spacing", n, 100);

    // mode change takes effect only at the next window start
    @(negedge clk); edge_mode = 1'b1;
    wait_valid(150, n);
    check("mode_late_ch0", ch_cnt(0), 10);
    wait_valid(150, n);
    check("both_ch0", ch_cnt(0), 20);
    check("both_ch1", ch_cnt(1), 10);
    repeat (50) @(negedge clk);
    edge_mode = 1'b0;
    wait_valid(150, n);
    check("both_kept_ch0", ch_cnt(0), 20);
    wait_valid(150, n);
    check("rise_again_ch0", ch_cnt(0), 10);

    // abort mid-window
    repeat (50) @(negedge clk);
    prev = ch_cnt(0);
    enable = 1'b0;
    @(posedge clk); #2;
    check("abort_busy", busy, 0);
    seen = 0;
    repeat (150) begin
      @(posedge clk); #2;
      if (count_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    check("abort_retained", ch_cnt(0), prev);

    // zero gate length never starts
    @(negedge clk); gate_len = 16'd0; enable = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #2;
      if (busy || count_valid) seen++;
    end
    check("gate0_idle", seen, 0);

    // saturation, then a short window clears overflow
    @(negedge clk); enable = 1'b0; period = '{4, 4, 8}; gate_len = 16'd300;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    gate_len = 16'd20;
    wait_valid(400, n);
    check("sat_ch0", ch_cnt(0), MAXC);
    check("sat_ovf0", overflow[0], 1);
    wait_valid(30, n);
    check("short_len", n, 20);
    check("short_ch0", ch_cnt(0), 5);
    check("short_ovf0", overflow[0], 0);

    // multi-channel slices
    @(negedge clk); enable = 1'b0; period = '{8, 16, 0}; gate_len = 16'd64;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    wait_valid(100, n);
    check("multi_ch0", ch_cnt(0), 8);
    check("multi_ch1", ch_cnt(1), 4);
    check("multi_ch2", ch_cnt(2), 0);
    check("multi_ovf", overflow, 0);

    // asynchronous reset mid-window
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_count_out", count_out, 0);
    check("async_busy", busy, 0);
    check("async_valid", count_valid, 0);
    check("async_ovf", overflow, 0);
    @(negedge clk); reset = 1'b0;
    wait_valid(100, n);
    check("first_after_reset", n, 65);

    // random traffic
    hold = '{3, 4, 5};
    rnd = '{1, 1, 1};
    for (int k = 0; k < 4000; k++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 299);
      if (r < 4) gate_len = GW'($urandom_range(1, 30));
      else if (r == 4) gate_len = GW'($urandom_range(100, 400));
      else if (r == 5) gate_len = 16'd0;
      else if (r < 9) edge_mode = ~edge_mode;
      else if (r < 11) enable = 1'b0;
      else if (!enable && r < 60) enable = 1'b1;
      else if (gate_len == 0 && r > 290) gate_len = 16'd7;
    end

    @(negedge clk); enable = 1'b0;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
